// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
//   Shared constants and types for the 5-stage pipeline. They are used by the
//   writeback register file, the MEM/WB pipeline register and the ID stage.
//   Contents:
//     DW, AW, NREG  data width, register-number width, register count
//     ZERO_REG      architectural register hardwired to zero
//     word_t        one data word
//     regnum_t      one register number
// -----------------------------------------------------------------------------
package pipe_pkg;

    localparam int DW   = 32;
    localparam int AW   = 5;
    localparam int NREG = 1 << AW;

    typedef logic [DW-1:0] word_t;
    typedef logic [AW-1:0] regnum_t;

    localparam regnum_t ZERO_REG = '0;

endpackage

// File: rtl/regfile_core.sv
// -----------------------------------------------------------------------------
// regfile_core
//   Raw NREG x DW register array. It has one synchronous write port, three
//   combinational read ports and an asynchronous clear. This module does no
//   r0 masking and no bypass. The caller handles both.
//   Ports:
//     clk        clock; the write takes effect on posedge
//     clrn       asynchronous active-low clear of every entry
//     we/wa/wd   write enable, address and data
//     ra0..ra2   read addresses
//     rd0..rd2   read data (array contents, combinational)
// -----------------------------------------------------------------------------
module regfile_core
    import pipe_pkg::*;
#(
    parameter int DW   = pipe_pkg::DW,
    parameter int AW   = pipe_pkg::AW,
    parameter int NREG = pipe_pkg::NREG
) (
    input  logic          clk,
    input  logic          clrn,
    input  logic          we,
    input  logic [AW-1:0] wa,
    input  logic [DW-1:0] wd,
    input  logic [AW-1:0] ra0,
    input  logic [AW-1:0] ra1,
    input  logic [AW-1:0] ra2,
    output logic [DW-1:0] rd0,
    output logic [DW-1:0] rd1,
    output logic [DW-1:0] rd2
);

    logic [DW-1:0] mem [NREG];

    // NOTE: the array is cleared by the asynchronous reset on purpose. The
    // architectural state must read as zero right after reset. This makes the
    // array flops rather than RAM, which is the intended implementation.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            for (int i = 0; i < NREG; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[wa] <= wd;
        end
    end

    assign rd0 = mem[ra0];
    assign rd1 = mem[ra1];
    assign rd2 = mem[ra2];

endmodule

// File: rtl/pipe_wb_regfile.sv
// -----------------------------------------------------------------------------
// pipe_wb_regfile
//   Writeback end of the 5-stage pipeline. The block:
//     - selects the writeback data (load data or ALU result),
//     - commits that data into the architectural register file,
//     - serves the two ID read ports, with optional same-cycle write-through,
//     - exposes the writeback data and enable to the forwarding unit,
//     - counts committed register writes.
//   Ports:
//     clk, clrn         clock and asynchronous active-low reset
//     wwreg, wm2reg     write request; select between load data and ALU result
//     wmo, walu, wrn    load data, ALU result, destination register
//     rna/qa, rnb/qb    ID read ports
//     wdi, wb_we        selected writeback data, effective write enable
//     dbg_rn/dbg_q      debug read port: raw array value, no bypass
//     wb_count          count of effective writes since reset (wraps)
// -----------------------------------------------------------------------------
module pipe_wb_regfile
    import pipe_pkg::*;
#(
    parameter int DW     = pipe_pkg::DW,
    parameter int AW     = pipe_pkg::AW,
    parameter int NREG   = pipe_pkg::NREG,
    parameter int BYPASS = 1
) (
    input  logic          clk,
    input  logic          clrn,
    input  logic          wwreg,
    input  logic          wm2reg,
    input  logic [DW-1:0] wmo,
    input  logic [DW-1:0] walu,
    input  logic [AW-1:0] wrn,
    input  logic [AW-1:0] rna,
    input  logic [AW-1:0] rnb,
    output logic [DW-1:0] qa,
    output logic [DW-1:0] qb,
    output logic [DW-1:0] wdi,
    output logic          wb_we,
    input  logic [AW-1:0] dbg_rn,
    output logic [DW-1:0] dbg_q,
    output logic [31:0]   wb_count
);

    localparam bit            BYP  = (BYPASS != 0);
    localparam logic [AW-1:0] REG0 = AW'(ZERO_REG);

    logic [DW-1:0] raw_a;
    logic [DW-1:0] raw_b;
    logic [DW-1:0] raw_d;
    logic          hit_a;
    logic          hit_b;
    logic [31:0]   wb_count_q;

    assign wdi = wm2reg ? wmo : walu;

    // A write to r0 is dropped here. It never reaches the array and never counts.
    assign wb_we = wwreg & (wrn != REG0);

    regfile_core #(
        .DW   (DW),
        .AW   (AW),
        .NREG (NREG)
    ) u_core (
        .clk  (clk),
        .clrn (clrn),
        .we   (wb_we),
        .wa   (wrn),
        .wd   (wdi),
        .ra0  (rna),
        .ra1  (rnb),
        .ra2  (dbg_rn),
        .rd0  (raw_a),
        .rd1  (raw_b),
        .rd2  (raw_d)
    );

    // Write-through: the ID stage sees the value being committed this cycle.
    assign hit_a = BYP && wb_we && (rna == wrn);
    assign hit_b = BYP && wb_we && (rnb == wrn);

    assign qa    = (rna == REG0)    ? '0 : hit_a ? wdi : raw_a;
    assign qb    = (rnb == REG0)    ? '0 : hit_b ? wdi : raw_b;
    assign dbg_q = (dbg_rn == REG0) ? '0 : raw_d;

    // NOTE: sequential state is updated with non-blocking assignments only.
    // This keeps every flop sampling pre-edge values regardless of block order.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wb_count_q <= '0;
        end else if (wb_we) begin
            wb_count_q <= wb_count_q + 32'd1;
        end
    end

    assign wb_count = wb_count_q;

endmodule
